// File: rtl/tx_packet_scheduler.sv
// Arbitrates host commands and RX auto-handshakes onto the shared USB TX engine and sequences each packet.
// Optional build macro TX_SCHED_RETRY_EN re-issues failed DATA packets up to MAX_RETRY extra times.
module tx_packet_scheduler #(
    parameter int START_TIMEOUT = 16,
    parameter int MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_req,
    input  logic [2:0] host_cmd,
    input  logic       auto_req,
    input  logic       auto_type,
    input  logic [6:0] buffer_occupancy,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    output logic       tx_start,
    output logic [1:0] tx_packet,
    output logic       host_grant,
    output logic       auto_grant,
    output logic       clear_tx_control,
    output logic       busy,
    output logic       done,
    output logic [1:0] err_code
);

    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_ISSUE       = 3'd1;
    localparam logic [2:0] S_WAIT_ACTIVE = 3'd2;
    localparam logic [2:0] S_WAIT_DONE   = 3'd3;
    localparam logic [2:0] S_REPORT      = 3'd4;

    logic [2:0]    state;
    logic [1:0]    pkt_reg;
    logic          pkt_host;
    logic          last_auto;
    logic [TW-1:0] to_cnt;
    logic          err_flag;
    logic [1:0]    reason;
    logic [1:0]    err_code_q;

    logic          pick_host;
    logic          host_bad;
    logic [2:0]    cmd_m1;
    logic [1:0]    host_code;
    logic [1:0]    auto_code;
    logic [1:0]    rep_code;
    logic          retry_go;
    logic          first_attempt;

    // Both pending: auto wins unless it also won last time, so the host cannot starve.
    assign pick_host = host_req && (!auto_req || last_auto);
    assign host_bad  = (host_cmd == 3'd0) || (host_cmd > 3'd4) ||
                       ((host_cmd == 3'd1) && (buffer_occupancy == 7'd0));
    assign cmd_m1    = host_cmd - 3'd1;
    assign host_code = cmd_m1[1:0];
    assign auto_code = {auto_type, ~auto_type};
    assign rep_code  = err_flag ? 2'b11 : reason;

`ifdef TX_SCHED_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    logic [RW-1:0] retry_cnt;

    assign retry_go = (state == S_REPORT) && (pkt_reg == 2'b00) &&
                      (err_flag || (reason == 2'b10)) && (retry_cnt < RETRY_MAX);
    assign first_attempt = (retry_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_cnt <= '0;
        end else if (state == S_IDLE) begin
            retry_cnt <= '0;
        end else if (retry_go) begin
            retry_cnt <= retry_cnt + RW'(1);
        end
    end
`else
    logic unused_max_retry;

    assign unused_max_retry = ^MAX_RETRY;
    assign retry_go         = 1'b0;
    assign first_attempt    = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pkt_reg    <= 2'b00;
            pkt_host   <= 1'b0;
            last_auto  <= 1'b0;
            to_cnt     <= '0;
            err_flag   <= 1'b0;
            reason     <= 2'b00;
            err_code_q <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (host_req || auto_req) begin
                        pkt_host  <= pick_host;
                        last_auto <= ~pick_host;
                        err_flag  <= 1'b0;
                        if (pick_host && host_bad) begin
                            state   <= S_REPORT;
                            reason  <= 2'b01;
                            pkt_reg <= 2'b00;
                        end else begin
                            state   <= S_ISSUE;
                            reason  <= 2'b00;
                            pkt_reg <= pick_host ? host_code : auto_code;
                        end
                    end
                end
                S_ISSUE: begin
                    to_cnt   <= '0;
                    err_flag <= 1'b0;
                    reason   <= 2'b00;
                    state    <= S_WAIT_ACTIVE;
                end
                S_WAIT_ACTIVE: begin
                    if (tx_error) begin
                        err_flag <= 1'b1;
                    end
                    to_cnt <= to_cnt + TW'(1);
                    // A start seen on the last allowed cycle still counts as a start.
                    if (tx_transfer_active) begin
                        state <= S_WAIT_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        state  <= S_REPORT;
                        reason <= 2'b10;
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_error) begin
                        err_flag <= 1'b1;
                    end
                    if (!tx_transfer_active) begin
                        state <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (retry_go) begin
                        state <= S_ISSUE;
                    end else begin
                        err_code_q <= rep_code;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy             = (state != S_IDLE);
    assign tx_start         = (state == S_ISSUE);
    assign tx_packet        = ((state == S_ISSUE) || (state == S_WAIT_ACTIVE) ||
                               (state == S_WAIT_DONE)) ? pkt_reg : 2'b00;
    // Rejected host commands are acknowledged in REPORT since they never reach ISSUE.
    assign host_grant       = ((state == S_ISSUE) && pkt_host && first_attempt) ||
                              ((state == S_REPORT) && (reason == 2'b01));
    assign auto_grant       = (state == S_ISSUE) && !pkt_host && first_attempt;
    assign clear_tx_control = host_grant;
    assign done             = (state == S_REPORT) && !retry_go;
    assign err_code         = done ? rep_code : err_code_q;

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Randomized bench for tx_packet_scheduler: the bench plays host, RX auto-handshake source and TX engine,
// and predicts each packet's winner, type, outcome and timing from the arbitration and timeout rules.
module tb_tx_packet_scheduler;

    localparam int START_TIMEOUT = 16;
    localparam int MAX_RETRY     = 3;
`ifdef TX_SCHED_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_req = 1'b0;
    logic [2:0] host_cmd = 3'd0;
    logic       auto_req = 1'b0;
    logic       auto_type = 1'b0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic       tx_transfer_active = 1'b0;
    logic       tx_error = 1'b0;
    logic       tx_start;
    logic [1:0] tx_packet;
    logic       host_grant;
    logic       auto_grant;
    logic       clear_tx_control;
    logic       busy;
    logic       done;
    logic [1:0] err_code;

    tx_packet_scheduler #(
        .START_TIMEOUT(START_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .host_req          (host_req),
        .host_cmd          (host_cmd),
        .auto_req          (auto_req),
        .auto_type         (auto_type),
        .buffer_occupancy  (buffer_occupancy),
        .tx_transfer_active(tx_transfer_active),
        .tx_error          (tx_error),
        .tx_start          (tx_start),
        .tx_packet         (tx_packet),
        .host_grant        (host_grant),
        .auto_grant        (auto_grant),
        .clear_tx_control  (clear_tx_control),
        .busy              (busy),
        .done              (done),
        .err_code          (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         host;
        bit         bad;
        logic [1:0] code;
        logic [1:0] err;
        int         attempts;
        int         tail;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    bit         lw_auto = 1'b0;
    logic [1:0] last_err = 2'b00;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        host_req = 1'b0;
        auto_req = 1'b0;
        tx_transfer_active = 1'b0;
        tx_error = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        lw_auto = 1'b0;
        last_err = 2'b00;
        exp_q.delete();
    endtask

    // One arbitration round started from IDLE: one or both requesters raise a request together,
    // and the engine answers every tx_start with the same behaviour (start delay, active length, error).
    task automatic run_round(input bit hr, input bit ar, input logic [2:0] cmd, input logic [6:0] occ,
                             input bit at, input int dly, input int len, input int eoff, input bit eon);
        exp_t e;
        bit   owners[$];
        bit   timeout;
        bit   eng_run;
        bit   fin;
        int   arb;
        int   s;
        int   t;
        int   starts;
        int   grants;

        timeout = (dly >= START_TIMEOUT);
        if (hr && ar) begin
            owners.push_back(lw_auto);
            owners.push_back(!lw_auto);
        end else begin
            owners.push_back(hr);
        end
        foreach (owners[i]) begin
            e.host = owners[i];
            if (e.host) begin
                e.bad  = (cmd == 3'd0) || (cmd > 3'd4) || ((cmd == 3'd1) && (occ == 7'd0));
                e.code = 2'(cmd - 3'd1);
            end else begin
                e.bad  = 1'b0;
                e.code = at ? 2'b10 : 2'b01;
            end
            e.err      = e.bad ? 2'b01 : timeout ? 2'b10 : eon ? 2'b11 : 2'b00;
            e.attempts = (RETRY && !e.bad && (e.code == 2'b00) && (e.err != 2'b00)) ? MAX_RETRY + 1 : 1;
            e.tail     = timeout ? START_TIMEOUT + 1 : dly + len + 2;
            exp_q.push_back(e);
        end
        lw_auto = !owners[owners.size() - 1];

        host_req = hr;
        auto_req = ar;
        host_cmd = cmd;
        buffer_occupancy = occ;
        auto_type = at;
        arb = cyc;
        eng_run = 1'b0;
        fin = 1'b0;
        s = 0;
        t = 0;
        starts = 0;
        grants = 0;

        for (int n = 0; n < 600 && !fin; n++) begin
            tick();
            if (eng_run) t++;
            if (host_grant || auto_grant || clear_tx_control) begin
                grants++;
                check_val("grant_owner", {host_grant, auto_grant}, exp_q[0].host ? 2'b10 : 2'b01);
                check_val("clear_tx_control", clear_tx_control, host_grant);
                if (host_grant) host_req = 1'b0;
                if (auto_grant) auto_req = 1'b0;
            end
            if (tx_start) begin
                starts++;
                if (starts == 1) check_val("issue_latency", cyc - arb, 1);
                check_val("tx_packet", tx_packet, exp_q[0].code);
                eng_run = 1'b1;
                t = 0;
                s = cyc;
            end
            if (done) begin
                check_val("err_code", err_code, exp_q[0].err);
                check_val("start_count", starts, exp_q[0].bad ? 0 : exp_q[0].attempts);
                check_val("grant_count", grants, 1);
                if (exp_q[0].bad) check_val("reject_latency", cyc - arb, 1);
                else check_val("done_latency", cyc - s, exp_q[0].tail);
                last_err = exp_q[0].err;
                e = exp_q.pop_front();
                eng_run = 1'b0;
                starts = 0;
                grants = 0;
                arb = cyc + 1;
                fin = (exp_q.size() == 0);
            end
            tx_transfer_active = eng_run && !timeout && (t >= dly + 1) && (t <= dly + len);
            // Errors outside the wait states (idle, issue, report) must not affect the outcome.
            tx_error = (eng_run && !timeout && eon && (t == dly + 1 + eoff)) ||
                       ((!eng_run || t == 0) && ($urandom_range(0, 3) == 0));
        end
        tx_transfer_active = 1'b0;
        tx_error = 1'b0;
        check_val("round_budget", fin, 1);
        if (!fin) begin
            do_reset();
        end else begin
            tick();
            check_val("idle_after_round", {busy, tx_start, done, tx_packet}, 0);
            check_val("err_code_held", err_code, last_err);
        end
    endtask

    task automatic reset_mid_packet();
        bit seen;
        seen = 1'b0;
        host_req = 1'b1;
        host_cmd = 3'd2;
        buffer_occupancy = 7'd5;
        auto_req = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            tick();
            if (tx_start) seen = 1'b1;
            if (host_grant) host_req = 1'b0;
        end
        check_val("rst_test_start", seen, 1);
        tx_transfer_active = 1'b1;
        repeat (4) tick();
        check_val("rst_test_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_val("rst_async_outputs",
                  {tx_start, tx_packet, host_grant, auto_grant, clear_tx_control, busy, done, err_code}, 0);
        tick();
        tx_transfer_active = 1'b0;
        check_val("rst_held_outputs", {busy, done, err_code, tx_packet}, 0);
        tick();
        rst = 1'b0;
        lw_auto = 1'b0;
        last_err = 2'b00;
    endtask

    initial begin
        bit         hr;
        bit         ar;
        logic [2:0] cmd;
        logic [6:0] occ;
        int         dly;
        int         len;

        #1;
        check_val("reset_outputs",
                  {tx_start, tx_packet, host_grant, auto_grant, clear_tx_control, busy, done, err_code}, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_val("idle_after_reset", busy, 0);

        run_round(1, 0, 3'd1, 7'd64, 0, 1, 10, 0, 0);
        run_round(1, 1, 3'd3, 7'd10, 0, 0, 3, 0, 0);
        run_round(0, 1, 3'd0, 7'd0, 1, 2, 2, 0, 0);
        run_round(1, 1, 3'd2, 7'd0, 0, 1, 1, 0, 0);
        run_round(1, 0, 3'd1, 7'd0, 0, 1, 1, 0, 0);
        run_round(1, 0, 3'd6, 7'd20, 0, 1, 1, 0, 0);
        run_round(1, 0, 3'd0, 7'd20, 0, 1, 1, 0, 0);
        run_round(1, 0, 3'd4, 7'd3, 0, 20, 1, 0, 0);
        run_round(0, 1, 3'd0, 7'd0, 0, 15, 2, 0, 0);
        run_round(0, 1, 3'd0, 7'd0, 1, 16, 2, 0, 0);
        run_round(1, 0, 3'd1, 7'd9, 0, 17, 1, 0, 0);
        run_round(1, 0, 3'd1, 7'd30, 0, 1, 6, 2, 1);
        reset_mid_packet();
        run_round(1, 0, 3'd2, 7'd1, 0, 3, 4, 0, 0);

        for (int r = 0; r < 200; r++) begin
            hr  = ($urandom_range(0, 3) != 0);
            ar  = ($urandom_range(0, 1) == 1);
            if (!hr && !ar) hr = 1'b1;
            cmd = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
            occ = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            dly = ($urandom_range(0, 5) == 0) ? START_TIMEOUT + $urandom_range(0, 4) : $urandom_range(0, 15);
            len = $urandom_range(1, 8);
            run_round(hr, ar, cmd, occ, 1'($urandom_range(0, 1)), dly, len,
                      $urandom_range(0, len - 1), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
